// File: rtl/normaliza_seq.sv
// Sequential post-add normalizer: one shift decision per clock until the hidden bit is set,
// then hands the normalized mantissa, exponent and flags to the round stage.
module normaliza_seq #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              sinal_in,
  input  logic [EXP_W-1:0]  expoente_in,
  input  logic [FRAC_W+4:0] mantissa_in,
  output logic              busy,
  output logic              done,
  output logic              sinal_out,
  output logic [EXP_W-1:0]  expoente_out,
  output logic [FRAC_W+3:0] mantissa_out,
  output logic              overflow,
  output logic              underflow,
  output logic              zero
);
  localparam int MW = FRAC_W + 5;
  localparam int HB = FRAC_W + 3;  // hidden bit
  localparam int CB = FRAC_W + 4;  // carry bit

  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [MW-1:0]    m_q, m_d;
  logic [EXP_W-1:0] e_q, e_d, e_inc;
  logic             s_q, s_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, zero_q, zero_d;

  assign e_inc = e_q + EXP_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      e_q     <= '0;
      s_q     <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      e_q     <= e_d;
      s_q     <= s_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    e_d     = e_q;
    s_d     = s_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = mantissa_in;
          e_d     = expoente_in;
          s_d     = sinal_in;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (m_q == '0) begin
          zero_d  = 1'b1;
          e_d     = '0;
          state_d = DONE;
        end else if (m_q[CB]) begin
          // Right shift by one; the bit falling off is folded into sticky.
          m_d     = {1'b0, m_q[MW-1:1]};
          m_d[0]  = m_q[1] | m_q[0];
          e_d     = e_inc;
          if (e_inc == '1) begin
            ovf_d       = 1'b1;
            m_d[HB:0]   = '0;
          end
          state_d = DONE;
        end else if (m_q[HB]) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (m_q[HB]) begin
          state_d = DONE;
        end else if (e_q <= EXP_W'(1)) begin
          // Exponent exhausted: leave the mantissa denormal.
          unf_d   = 1'b1;
          e_d     = '0;
          state_d = DONE;
        end else begin
          m_d = m_q << 1;
          e_d = e_q - EXP_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign sinal_out    = s_q;
  assign expoente_out = e_q;
  assign mantissa_out = m_q[HB:0];
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign zero         = zero_q;
endmodule

// File: tb/tb_normaliza_seq.sv
// Directed bench for normaliza_seq: hand-computed vectors checked with immediate assertions.
module tb_normaliza_seq;
  logic        clock = 1'b0;
  logic        reset, start, sinal_in;
  logic [7:0]  expoente_in;
  logic [27:0] mantissa_in;
  logic        busy, done, sinal_out, overflow, underflow, zero;
  logic [7:0]  expoente_out;
  logic [26:0] mantissa_out;

  int n_checks = 0;
  int n_fails  = 0;

  normaliza_seq #(.EXP_W(8), .FRAC_W(23)) dut (
    .clock(clock), .reset(reset), .start(start), .sinal_in(sinal_in),
    .expoente_in(expoente_in), .mantissa_in(mantissa_in),
    .busy(busy), .done(done), .sinal_out(sinal_out), .expoente_out(expoente_out),
    .mantissa_out(mantissa_out), .overflow(overflow), .underflow(underflow), .zero(zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic s, input logic [7:0] e,
                            input logic [26:0] m, input logic ov, input logic un, input logic z);
    check({tag, " sinal"},     {31'd0, sinal_out},    {31'd0, s});
    check({tag, " expoente"},  {24'd0, expoente_out}, {24'd0, e});
    check({tag, " mantissa"},  {5'd0, mantissa_out},  {5'd0, m});
    check({tag, " overflow"},  {31'd0, overflow},     {31'd0, ov});
    check({tag, " underflow"}, {31'd0, underflow},    {31'd0, un});
    check({tag, " zero"},      {31'd0, zero},         {31'd0, z});
  endtask

  // Issue one op; optionally pulse a bogus start at cycle pulse_at while busy.
  task automatic run_op(input string tag, input logic s, input logic [7:0] e_in,
                        input logic [27:0] m_in, input int lat, input int pulse_at,
                        input logic [7:0] e_x, input logic [26:0] m_x,
                        input logic ov, input logic un, input logic z);
    int c, nb;
    sinal_in = s; expoente_in = e_in; mantissa_in = m_in; start = 1'b1;
    tick();
    start = 1'b0;
    c = 1; nb = 0;
    while (!done && c < 60) begin
      if (!busy) nb++;
      if (c == pulse_at) begin
        start = 1'b1; sinal_in = ~s; expoente_in = 8'd1; mantissa_in = 28'h8000000;
      end else start = 1'b0;
      tick();
      c++;
    end
    start = 1'b0;
    check({tag, " latency"}, c, lat);
    check({tag, " busy-gap"}, nb, 0);
    check_outs(tag, s, e_x, m_x, ov, un, z);
    // start in the DONE cycle must be ignored
    start = 1'b1; sinal_in = ~s; expoente_in = 8'd5; mantissa_in = 28'h0000001;
    tick();
    start = 1'b0;
    check({tag, " done-pulse"}, {31'd0, done}, 32'd0);
    check({tag, " idle-after"}, {31'd0, busy}, 32'd0);
    tick();
    check({tag, " still-idle"}, {31'd0, busy}, 32'd0);
    check_outs({tag, " hold"}, s, e_x, m_x, ov, un, z);
  endtask

  initial begin
    int nd;
    reset = 1'b1; start = 1'b0; sinal_in = 1'b0; expoente_in = '0; mantissa_in = '0;
    tick(); tick();
    start = 1'b1;  // reset wins over start
    tick();
    start = 1'b0;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check_outs("rst", 1'b0, 8'd0, 27'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();

    run_op("one_plus_one", 1'b0, 8'd127, 28'h8000000, 2, 0, 8'd128, 27'h4000000, 0, 0, 0);
    run_op("sticky",       1'b1, 8'd100, 28'h8000003, 2, 0, 8'd101, 27'h4000001, 0, 0, 0);
    run_op("normal",       1'b0, 8'd10,  28'h4000005, 2, 0, 8'd10,  27'h4000005, 0, 0, 0);
    run_op("cancel_k6",    1'b0, 8'd127, 28'h0100000, 9, 0, 8'd121, 27'h4000000, 0, 0, 0);
    run_op("busy_start",   1'b1, 8'd127, 28'h0100000, 9, 3, 8'd121, 27'h4000000, 0, 0, 0);
    run_op("zero",         1'b1, 8'd77,  28'h0000000, 2, 0, 8'd0,   27'h0000000, 0, 0, 1);
    run_op("overflow",     1'b0, 8'd254, 28'h8000000, 2, 0, 8'd255, 27'h0000000, 1, 0, 0);
    run_op("underflow",    1'b0, 8'd3,   28'h0100000, 5, 0, 8'd0,   27'h0400000, 0, 1, 0);
    run_op("k26",          1'b0, 8'd100, 28'h0000001, 29, 0, 8'd74, 27'h4000000, 0, 0, 0);

    // Reset in cycle N+4 of a k=6 op: abort, no done pulse.
    sinal_in = 1'b1; expoente_in = 8'd127; mantissa_in = 28'h0100000; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("abort busy-before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check_outs("abort", 1'b0, 8'd0, 27'd0, 1'b0, 1'b0, 1'b0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) nd++;
      tick();
    end
    check("abort quiet", nd, 0);

    run_op("recover", 1'b0, 8'd127, 28'h8000000, 2, 0, 8'd128, 27'h4000000, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
